// File: rtl/jpl_foc_inv_clarke_if.sv
// Handshake and data bundle for the inverse Clarke stage: start/alpha/beta in,
// busy/done/phase voltages/saturation flag out.
interface jpl_foc_inv_clarke_if #(
  parameter int unsigned B = 12
);
  logic                start;
  logic signed [B-1:0] valpha;
  logic signed [B-1:0] vbeta;
  logic                busy;
  logic                done;
  logic signed [B-1:0] va;
  logic signed [B-1:0] vb;
  logic signed [B-1:0] vc;
  logic                sat;

  modport master (
    output start, valpha, vbeta,
    input  busy, done, va, vb, vc, sat
  );

  modport slave (
    input  start, valpha, vbeta,
    output busy, done, va, vb, vc, sat
  );
endinterface

// File: rtl/jpl_foc_inv_clarke.sv
// Inverse Clarke transform (alpha,beta) -> (a,b,c) with a serial shift-add
// multiply by sqrt(3)/2 and saturated b/c outputs.
module jpl_foc_inv_clarke #(
  parameter int unsigned B         = 12,
  parameter int unsigned K_W       = 12,
  parameter int unsigned K_SQRT3_2 = 3547
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  jpl_foc_inv_clarke_if.slave   bus
);
  localparam int unsigned AW = B + K_W + 1;
  localparam int unsigned SW = B + 2;
  localparam int unsigned CW = (K_W > 1) ? $clog2(K_W) : 1;

  localparam logic [K_W-1:0]       KC       = K_W'(K_SQRT3_2);
  localparam logic [CW-1:0]        CNT_LAST = CW'(K_W - 1);
  localparam logic signed [AW-1:0] RND      = {{(AW-K_W){1'b0}}, 1'b1, {(K_W-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV     = {3'b000, {(B-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV     = {3'b111, {(B-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, SUM} state_t;

  state_t state, state_nx;
  logic   load, mul_step, sum_step;

  logic signed [B-1:0]  valpha_q, vbeta_q;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;

  logic signed [AW-1:0] vbeta_x, addend, prod_full;
  logic signed [SW-1:0] valpha_x, half, prod, vb_w, vc_w;
  logic signed [B-1:0]  vb_s, vc_s;
  logic                 vb_clip, vc_clip;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = MUL;
      MUL:     if (cnt == CNT_LAST) state_nx = SUM;
      SUM:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    load     = (state == IDLE) && bus.start;
    mul_step = (state == MUL);
    sum_step = (state == SUM);
  end

  // Both extensions are built as signed vectors first so the arithmetic
  // shifts below replicate the sign bit instead of shifting in zeros.
  always_comb begin
    vbeta_x   = {{(AW-B){vbeta_q[B-1]}}, vbeta_q};
    addend    = vbeta_x <<< cnt;
    prod_full = (acc + RND) >>> K_W;
    prod      = prod_full[SW-1:0];
    valpha_x  = {{2{valpha_q[B-1]}}, valpha_q};
    half      = valpha_x >>> 1;
    vb_w      = prod - half;
    vc_w      = -half - prod;
    vb_clip   = (vb_w > MAXV) || (vb_w < MINV);
    vc_clip   = (vc_w > MAXV) || (vc_w < MINV);
    vb_s      = (vb_w > MAXV) ? MAXV[B-1:0] : (vb_w < MINV) ? MINV[B-1:0] : vb_w[B-1:0];
    vc_s      = (vc_w > MAXV) ? MAXV[B-1:0] : (vc_w < MINV) ? MINV[B-1:0] : vc_w[B-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valpha_q <= '0;
      vbeta_q  <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.va   <= '0;
      bus.vb   <= '0;
      bus.vc   <= '0;
      bus.sat  <= 1'b0;
    end else begin
      bus.done <= sum_step;
      if (load) begin
        valpha_q <= bus.valpha;
        vbeta_q  <= bus.vbeta;
        acc      <= '0;
        cnt      <= '0;
      end
      if (mul_step) begin
        if (KC[cnt]) acc <= acc + addend;
        cnt <= cnt + CW'(1);
      end
      if (sum_step) begin
        bus.va  <= valpha_q;
        bus.vb  <= vb_s;
        bus.vc  <= vc_s;
        bus.sat <= vb_clip || vc_clip;
      end
    end
  end
endmodule

// File: tb/tb_jpl_foc_inv_clarke.sv
// Directed and random checks of the inverse Clarke stage against a real-valued
// reference of the transform with round-half-up and clamping.
module tb_jpl_foc_inv_clarke;
  localparam int B  = 12;
  localparam int KW = 12;
  localparam int K  = 3547;
  localparam int LAT = KW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jpl_foc_inv_clarke_if #(.B(B)) bus();

  jpl_foc_inv_clarke #(.B(B), .K_W(KW), .K_SQRT3_2(K)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_dones = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, output int clipped);
    int hi = 2**(B-1) - 1;
    int lo = -(2**(B-1));
    clipped = (v > hi || v < lo) ? 1 : 0;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic void model(input int a, input int b,
                                output int va, output int vb, output int vc, output int sat);
    int prod, half, cb, cc;
    prod = int'($floor((real'(b) * real'(K) + 2.0**(KW-1)) / 2.0**KW));
    half = int'($floor(real'(a) / 2.0));
    va   = a;
    vb   = clamp(prod - half, cb);
    vc   = clamp(-half - prod, cc);
    sat  = cb | cc;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_outputs(input string tag, input int a, input int b);
    int va, vb, vc, sat;
    model(a, b, va, vb, vc, sat);
    chk({tag, "_va"},  int'(bus.va), va);
    chk({tag, "_vb"},  int'(bus.vb), vb);
    chk({tag, "_vc"},  int'(bus.vc), vc);
    chk({tag, "_sat"}, int'(bus.sat), sat);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Entered and left at posedge+1; returns in the o_done cycle.
  task automatic run_op(input string tag, input int a, input int b);
    int n;
    bus.start  = 1'b1;
    bus.valpha = B'(a);
    bus.vbeta  = B'(b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_run"}, int'(bus.busy), 1);
    wait_done(n);
    exp_dones++;
    chk({tag, "_latency"}, n, LAT);
    check_outputs(tag, a, b);
  endtask

  initial begin
    int n;
    logic signed [B-1:0] r;
    int ra, rb;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.valpha = '0;
    bus.vbeta  = '0;
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_va",   int'(bus.va), 0);
    chk("rst_vb",   int'(bus.vb), 0);
    chk("rst_vc",   int'(bus.vc), 0);
    chk("rst_sat",  int'(bus.sat), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 plus done pulse width and output hold
    run_op("t1", 1000, 0);
    chk("t1_vb_const", int'(bus.vb), -500);
    @(posedge clk); #1;
    chk("t1_done_pulse", int'(bus.done), 0);
    chk("t1_hold_va", int'(bus.va), 1000);
    repeat (3) @(posedge clk);
    #1;

    run_op("t2p", 0, 1000);
    chk("t2p_vb_const", int'(bus.vb), 866);
    run_op("t2n", 0, -1000);
    chk("t2n_vb_const", int'(bus.vb), -866);
    run_op("t3", -1001, 0);
    chk("t3_vc_const", int'(bus.vc), 501);
    run_op("t4", -2048, 2047);
    chk("t4_vc_const", int'(bus.vc), -749);
    chk("t4_sat_const", int'(bus.sat), 1);
    run_op("t4z", 0, 0);

    // T5: start while busy is ignored, changed inputs have no effect
    bus.start = 1'b1; bus.valpha = B'(100); bus.vbeta = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; n++; end
    bus.start = 1'b1; bus.valpha = B'(200);
    @(posedge clk); #1; n++;
    bus.start = 1'b0; bus.valpha = B'(555); bus.vbeta = B'(77);
    while (bus.done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    exp_dones++;
    chk("t5_latency", n, LAT);
    check_outputs("t5", 100, 0);
    run_op("t5b2b", 300, -400);

    // T6: reset mid-operation
    @(posedge clk); #1;
    run_op("t6pre", 700, -200);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.valpha = B'(500); bus.vbeta = B'(300);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); end
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_done", int'(bus.done), 0);
    chk("t6_va",   int'(bus.va), 0);
    chk("t6_vb",   int'(bus.vb), 0);
    chk("t6_vc",   int'(bus.vc), 0);
    chk("t6_sat",  int'(bus.sat), 0);
    repeat (15) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("t6_no_done", done_cnt, exp_dones);
    @(posedge clk); #1;
    run_op("t6post", -321, 654);

    // full-scale corners
    run_op("fs0", -2048, -2048);
    run_op("fs1", 2047, 2047);
    run_op("fs2", 2047, -2048);
    run_op("fs3", -2048, 0);

    // randomized operations, some back-to-back, some with idle gaps
    for (int i = 0; i < 24; i++) begin
      r  = B'($urandom); ra = int'(r);
      r  = B'($urandom); rb = int'(r);
      run_op($sformatf("rnd%0d", i), ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    @(posedge clk); #1;
    chk("done_count", done_cnt, exp_dones);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
